// File: rtl/fetch_unit.sv
// Fetch-stage PC register with a 64-entry direct-mapped branch predictor.
// Each entry holds a tag, a target and a 2-bit counter; lookup is combinational on pcF.
module fetch_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        fail_predict,
  input  logic [12:0] redirect_pc,
  input  logic        update_en,
  input  logic [12:0] update_pc,
  input  logic        update_taken,
  input  logic [12:0] update_target,
  output logic [12:0] pcF,
  output logic        pred_takenF,
  output logic [12:0] pred_targetF
);

  logic [12:0] pc_q, pc_d;

  logic        valid_q  [64];
  logic [4:0]  tag_q    [64];
  logic [12:0] target_q [64];
  logic [1:0]  ctr_q    [64];

  logic [5:0]  lookIdx;
  logic        lookHit;
  logic [5:0]  updIdx;
  logic [4:0]  updTag;
  logic        updHit;
  logic [12:0] updTarget;

  assign pcF = pc_q;

  // Lookup reads the table as it stands before this edge's update.
  always_comb begin
    lookIdx      = pc_q[7:2];
    lookHit      = valid_q[lookIdx] && (tag_q[lookIdx] == pc_q[12:8]);
    pred_takenF  = lookHit && ctr_q[lookIdx][1];
    pred_targetF = target_q[lookIdx];
  end

  always_comb begin
    updIdx    = update_pc[7:2];
    updTag    = update_pc[12:8];
    updHit    = valid_q[updIdx] && (tag_q[updIdx] == updTag);
    updTarget = {update_target[12:2], 2'b00};
  end

  always_comb begin
    pc_d = {pc_q[12:2] + 11'd1, 2'b00};
    if (fail_predict)
      pc_d = {redirect_pc[12:2], 2'b00};
    else if (stall)
      pc_d = pc_q;
    else if (pred_takenF)
      pc_d = pred_targetF;
  end

  always_ff @(posedge CLK) begin
    if (RST)
      pc_q <= 13'h0000;
    else
      pc_q <= pc_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 64; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (update_en) begin
      if (updHit) begin
        if (update_taken && ctr_q[updIdx] != 2'b11)
          ctr_q[updIdx] <= ctr_q[updIdx] + 2'b01;
        else if (!update_taken && ctr_q[updIdx] != 2'b00)
          ctr_q[updIdx] <= ctr_q[updIdx] - 2'b01;
      end else if (update_taken) begin
        valid_q[updIdx] <= 1'b1;
        ctr_q[updIdx]   <= 2'b10;
      end
    end
  end

  // Tag and target need no reset; a taken update on a hit rewrites the same tag.
  always_ff @(posedge CLK) begin
    if (!RST && update_en && update_taken) begin
      tag_q[updIdx]    <= updTag;
      target_q[updIdx] <= updTarget;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes hand-computed expectations
// into a queue, a negedge monitor pops and compares against pcF / prediction.
module tb_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        stall;
  logic        fail_predict;
  logic [12:0] redirect_pc;
  logic        update_en;
  logic [12:0] update_pc;
  logic        update_taken;
  logic [12:0] update_target;
  logic [12:0] pcF;
  logic        pred_takenF;
  logic [12:0] pred_targetF;

  typedef struct {
    int          id;
    logic [12:0] pc;
    logic        taken;
    logic [12:0] target;
  } expect_t;

  expect_t expQ[$];
  int      vecCount = 0;
  int      missCount = 0;
  int      stepId = 0;

  fetch_unit dut (
    .CLK          (CLK),
    .RST          (RST),
    .stall        (stall),
    .fail_predict (fail_predict),
    .redirect_pc  (redirect_pc),
    .update_en    (update_en),
    .update_pc    (update_pc),
    .update_taken (update_taken),
    .update_target(update_target),
    .pcF          (pcF),
    .pred_takenF  (pred_takenF),
    .pred_targetF (pred_targetF)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Drive this cycle's inputs and record what the outputs must show during it.
  task automatic applyStimulus(input logic rst, input logic stl, input logic fp,
                               input logic [12:0] rpc, input logic uen,
                               input logic [12:0] upc, input logic utk,
                               input logic [12:0] utgt, input logic [12:0] ePc,
                               input logic eTk, input logic [12:0] eTgt);
    expect_t e;
    @(posedge CLK);
    #1;
    RST           = rst;
    stall         = stl;
    fail_predict  = fp;
    redirect_pc   = rpc;
    update_en     = uen;
    update_pc     = upc;
    update_taken  = utk;
    update_target = utgt;
    stepId++;
    e.id     = stepId;
    e.pc     = ePc;
    e.taken  = eTk;
    e.target = eTgt;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    logic bad;
    bad = (pcF !== e.pc) || (pred_takenF !== e.taken) ||
          (e.taken && (pred_targetF !== e.target));
    vecCount++;
    if (bad) begin
      missCount++;
      $display("[TB] FAIL vec%0d: got pcF=%h taken=%b target=%h, want pcF=%h taken=%b target=%h",
               e.id, pcF, pred_takenF, pred_targetF, e.pc, e.taken, e.target);
    end
  endtask

  always @(negedge CLK) begin
    if (expQ.size() > 0)
      checkOutput(expQ.pop_front());
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish, got stuck, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    RST = 1'b1; stall = 1'b0; fail_predict = 1'b0; redirect_pc = '0;
    update_en = 1'b0; update_pc = '0; update_taken = 1'b0; update_target = '0;
    repeat (2) @(posedge CLK);

    //            rst  stl  fp   rpc      uen  upc      utk  utgt     ePc      eTk  eTgt
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b0,13'h000, 1'b0,13'h000, 13'h000, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b0,13'h000, 1'b0,13'h000, 13'h004, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b0,13'h000, 1'b0,13'h000, 13'h008, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b0,13'h000, 1'b0,13'h000, 13'h00C, 1'b0,13'h000);
    applyStimulus(1'b0,1'b1,1'b0,13'h000, 1'b0,13'h000, 1'b0,13'h000, 13'h010, 1'b0,13'h000);
    applyStimulus(1'b0,1'b1,1'b0,13'h000, 1'b0,13'h000, 1'b0,13'h000, 13'h010, 1'b0,13'h000);
    applyStimulus(1'b0,1'b1,1'b0,13'h000, 1'b0,13'h000, 1'b0,13'h000, 13'h010, 1'b0,13'h000);
    applyStimulus(1'b0,1'b1,1'b1,13'h123, 1'b0,13'h000, 1'b0,13'h000, 13'h010, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b1,13'h040, 1'b1,13'h100, 13'h120, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b1,13'h040, 1'b0,13'h000, 1'b0,13'h000, 13'h124, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b0,13'h000, 1'b0,13'h000, 13'h040, 1'b1,13'h100);
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b1,13'h040, 1'b0,13'h000, 13'h100, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b1,13'h040, 1'b0,13'h000, 13'h104, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b1,13'h040, 1'b0,13'h000, 1'b0,13'h000, 13'h108, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b1,13'h040, 1'b1,13'h100, 13'h040, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b1,13'h040, 1'b1,13'h100, 13'h044, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b1,13'h040, 1'b1,13'h100, 13'h048, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b1,13'h040, 1'b1,13'h100, 13'h04C, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b1,13'h040, 1'b1,13'h040, 1'b0,13'h000, 13'h050, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b1,13'h140, 1'b0,13'h000, 1'b0,13'h000, 13'h040, 1'b1,13'h100);
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b1,13'h140, 1'b0,13'h000, 13'h140, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b1,13'h040, 1'b0,13'h000, 1'b0,13'h000, 13'h144, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b1,13'h040, 1'b0,13'h000, 13'h040, 1'b1,13'h100);
    applyStimulus(1'b0,1'b0,1'b1,13'h040, 1'b0,13'h000, 1'b0,13'h000, 13'h100, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b1,13'h040, 1'b1,13'h203, 13'h040, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b1,13'h040, 1'b0,13'h000, 1'b0,13'h000, 13'h044, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b1,13'h1FFF,1'b0,13'h000, 1'b0,13'h000, 13'h040, 1'b1,13'h200);
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b1,13'h1FFC,1'b1,13'h0A0, 13'h1FFC,1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b1,13'h1FFC,1'b0,13'h000, 1'b0,13'h000, 13'h000, 1'b0,13'h000);
    applyStimulus(1'b0,1'b1,1'b0,13'h000, 1'b0,13'h000, 1'b0,13'h000, 13'h1FFC,1'b1,13'h0A0);
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b0,13'h000, 1'b0,13'h000, 13'h1FFC,1'b1,13'h0A0);
    applyStimulus(1'b1,1'b0,1'b1,13'h040, 1'b1,13'h0A0, 1'b1,13'h300, 13'h0A0, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b1,13'h0A0, 1'b0,13'h000, 1'b0,13'h000, 13'h000, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b1,13'h1FFC,1'b0,13'h000, 1'b0,13'h000, 13'h0A0, 1'b0,13'h000);
    applyStimulus(1'b0,1'b0,1'b0,13'h000, 1'b0,13'h000, 1'b0,13'h000, 13'h1FFC,1'b0,13'h000);

    @(posedge CLK);
    @(posedge CLK);
    #1;
    if (expQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
